// File: rtl/int_iq3_pkg.sv
// Shared widths, slot entry layout and tag-to-slot mapping for the IQ3 issue queue.
package int_iq3_pkg;

  localparam int unsigned TAGW  = 5;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PRW   = 6;
  localparam int unsigned PAYW  = 32;
  localparam int unsigned SLOTW = $clog2(DEPTH);

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [PAYW-1:0] payload;
    logic [PRW-1:0]  src1;
    logic [PRW-1:0]  src2;
    logic            rdy1;
    logic            rdy2;
  } entry_t;

  // Free-list tags are 4*slot+2, so the slot lives in bits [SLOTW+1:2].
  function automatic logic [SLOTW-1:0] tag2slot(input logic [TAGW-1:0] tag);
    return tag[SLOTW+1:2];
  endfunction

endpackage

// File: rtl/int_iq3_age_sel.sv
// Oldest-eligible picker: grants the eligible slot with no older eligible slot in the age matrix.
module int_iq3_age_sel
  import int_iq3_pkg::*;
#(
  parameter int unsigned NumSlots = DEPTH
) (
  input  logic [NumSlots-1:0]               elig_i,
  input  logic [NumSlots-1:0][NumSlots-1:0] age_i,
  output logic [NumSlots-1:0]               gnt_o,
  output logic                              valid_o
);

  // age_i[i][j] set means slot j is older than slot i.
  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < NumSlots; i++) begin
      gnt_o[i] = elig_i[i] && !(|(elig_i & age_i[i]));
    end
  end

  assign valid_o = |elig_i;

endmodule

// File: rtl/int_iq3_queue.sv
// Eight-slot issue queue: free-list-tag allocation, wakeup, age-ordered issue and tag release.
module int_iq3_queue #(
  parameter int unsigned TAGW  = int_iq3_pkg::TAGW,
  parameter int unsigned DEPTH = int_iq3_pkg::DEPTH,
  parameter int unsigned PRW   = int_iq3_pkg::PRW,
  parameter int unsigned PAYW  = int_iq3_pkg::PAYW
) (
  input  logic            Clk,
  input  logic            Rest,
  input  logic            DispValid,
  output logic            DispReady,
  input  logic [PAYW-1:0] DispPayload,
  input  logic [PRW-1:0]  DispSrc1,
  input  logic [PRW-1:0]  DispSrc2,
  input  logic            DispSrc1Rdy,
  input  logic            DispSrc2Rdy,
  output logic            FlPop,
  input  logic [TAGW-1:0] FlTag,
  input  logic            FlEmpty,
  output logic            FlPush,
  output logic [TAGW-1:0] FlRetTag,
  output logic            FlClean,
  input  logic            WkValid,
  input  logic [PRW-1:0]  WkPreg,
  output logic            IssValid,
  input  logic            IssReady,
  output logic [TAGW-1:0] IssTag,
  output logic [PAYW-1:0] IssPayload,
  input  logic            Flush
);

  int_iq3_pkg::entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [DEPTH-1:0][DEPTH-1:0]   age_q, age_d;

  logic                          accept, fire, any_elig;
  logic [int_iq3_pkg::SLOTW-1:0] alloc_slot;
  logic [DEPTH-1:0]              elig, gnt, rel;
  int_iq3_pkg::entry_t           iss_ent;

  assign DispReady  = !FlEmpty && !Flush && !Rest;
  assign accept     = DispValid && DispReady;
  assign FlPop      = accept;
  assign alloc_slot = int_iq3_pkg::tag2slot(FlTag);

  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = valid_q[i] && ent_q[i].rdy1 && ent_q[i].rdy2;
    end
  end

  int_iq3_age_sel #(
    .NumSlots(DEPTH)
  ) u_age_sel (
    .elig_i (elig),
    .age_i  (age_q),
    .gnt_o  (gnt),
    .valid_o(any_elig)
  );

  always_comb begin
    iss_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (gnt[i]) iss_ent = ent_q[i];
    end
  end

  assign IssValid   = any_elig && !Flush && !Rest;
  assign IssTag     = Rest ? '0 : iss_ent.tag;
  assign IssPayload = Rest ? '0 : iss_ent.payload;
  assign fire       = IssValid && IssReady;
  assign FlPush     = fire;
  assign FlRetTag   = IssTag;
  assign FlClean    = Flush || Rest;
  assign rel        = fire ? gnt : '0;

  always_comb begin
    valid_d = valid_q & ~rel;
    ent_d   = ent_q;
    age_d   = age_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (WkValid && valid_q[i]) begin
        if (ent_q[i].src1 == WkPreg) ent_d[i].rdy1 = 1'b1;
        if (ent_q[i].src2 == WkPreg) ent_d[i].rdy2 = 1'b1;
      end
      age_d[i] = age_q[i] & ~rel;
    end

    if (accept) begin
      valid_d[alloc_slot]         = 1'b1;
      ent_d[alloc_slot].tag       = FlTag;
      ent_d[alloc_slot].payload   = DispPayload;
      ent_d[alloc_slot].src1      = DispSrc1;
      ent_d[alloc_slot].src2      = DispSrc2;
      ent_d[alloc_slot].rdy1      = DispSrc1Rdy || (WkValid && (WkPreg == DispSrc1));
      ent_d[alloc_slot].rdy2      = DispSrc2Rdy || (WkValid && (WkPreg == DispSrc2));
      // An entry issuing this cycle is gone before the new one could wait on it.
      age_d[alloc_slot]           = valid_q & ~rel;
    end

    if (Flush) begin
      valid_d = '0;
      age_d   = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      valid_q <= '0;
      ent_q   <= '0;
      age_q   <= '0;
    end else begin
      if (accept) begin
        assert (!valid_q[alloc_slot]) else $error("dispatch into an occupied slot");
      end
      valid_q <= valid_d;
      ent_q   <= ent_d;
      age_q   <= age_d;
    end
  end

endmodule

// File: tb/tb_int_iq3_queue.sv
// Bench for int_iq3_queue: free-list model, vector table plus hand sequences, issue scoreboard.
module tb_int_iq3_queue;

  logic        Clk = 1'b0;
  logic        Rest = 1'b1;
  logic        DispValid = 1'b0, DispReady;
  logic [31:0] DispPayload = '0;
  logic [5:0]  DispSrc1 = '0, DispSrc2 = '0;
  logic        DispSrc1Rdy = 1'b0, DispSrc2Rdy = 1'b0;
  logic        FlPop, FlPush, FlClean;
  logic [4:0]  FlTag = '0, FlRetTag;
  logic        FlEmpty = 1'b1;
  logic        WkValid = 1'b0;
  logic [5:0]  WkPreg = '0;
  logic        IssValid, IssReady = 1'b0;
  logic [4:0]  IssTag;
  logic [31:0] IssPayload;
  logic        Flush = 1'b0;

  always #5 Clk = ~Clk;

  int_iq3_queue dut (
    .Clk(Clk), .Rest(Rest), .DispValid(DispValid), .DispReady(DispReady),
    .DispPayload(DispPayload), .DispSrc1(DispSrc1), .DispSrc2(DispSrc2),
    .DispSrc1Rdy(DispSrc1Rdy), .DispSrc2Rdy(DispSrc2Rdy), .FlPop(FlPop), .FlTag(FlTag),
    .FlEmpty(FlEmpty), .FlPush(FlPush), .FlRetTag(FlRetTag), .FlClean(FlClean),
    .WkValid(WkValid), .WkPreg(WkPreg), .IssValid(IssValid), .IssReady(IssReady),
    .IssTag(IssTag), .IssPayload(IssPayload), .Flush(Flush)
  );

  typedef struct {
    logic       disp;
    logic [5:0] s1;
    logic       r1;
    logic [5:0] s2;
    logic       r2;
    logic       wk;
    logic [5:0] wkp;
    logic       irdy;
    logic       flush;
    logic       e_drdy;
    logic       e_ivalid;
    logic [4:0] e_itag;
    logic       e_push;
  } vec_t;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] pay;
  } sb_t;

  int          n_pass = 0;
  int          n_tot = 0;
  int unsigned n_disp = 0;
  logic [31:0] cur_pay = '0;
  logic [31:0] pay_a, pay_b;
  sb_t         sb[$];
  logic [4:0]  fl_q[$];
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Free-list model: FIFO of tags 2,6,...,30, refilled in order on FlClean.
  always @(posedge Clk) begin
    if (FlClean) begin
      fl_q.delete();
      for (int k = 0; k < 8; k++) fl_q.push_back(5'(4 * k + 2));
    end else begin
      if (FlPop && fl_q.size() > 0) void'(fl_q.pop_front());
      if (FlPush) fl_q.push_back(FlRetTag);
    end
    FlTag   <= (fl_q.size() > 0) ? fl_q[0] : 5'd0;
    FlEmpty <= (fl_q.size() == 0);
  end

  // Every release must match the next expected issue in order.
  always @(posedge Clk) begin
    if (!Rest && FlPush) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL sb_unexpected_push: got tag %0d, wanted no push (t=%0t)", FlRetTag, $time);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_ret_tag", 32'(FlRetTag), 32'(e.tag));
        chk("sb_payload", IssPayload, e.pay);
      end
    end
  end

  function automatic vec_t mkv(input int disp, input int s1, input int r1, input int s2,
                               input int r2, input int wk, input int wkp, input int irdy,
                               input int flush, input int drdy, input int iv, input int itag,
                               input int push);
    vec_t v;
    v.disp = 1'(disp);  v.s1 = 6'(s1);   v.r1 = 1'(r1);     v.s2 = 6'(s2);
    v.r2 = 1'(r2);      v.wk = 1'(wk);   v.wkp = 6'(wkp);   v.irdy = 1'(irdy);
    v.flush = 1'(flush); v.e_drdy = 1'(drdy); v.e_ivalid = 1'(iv);
    v.e_itag = 5'(itag); v.e_push = 1'(push);
    return v;
  endfunction

  task automatic step(input vec_t v, input bit auto_sb);
    @(negedge Clk);
    DispValid = v.disp;  DispSrc1 = v.s1;  DispSrc1Rdy = v.r1;
    DispSrc2 = v.s2;     DispSrc2Rdy = v.r2;
    WkValid = v.wk;      WkPreg = v.wkp;   IssReady = v.irdy;  Flush = v.flush;
    n_disp++;
    cur_pay = 32'hC0DE_0000 + 32'(n_disp);
    DispPayload = cur_pay;
    #1;
    chk("disp_ready", 32'(DispReady), 32'(v.e_drdy));
    chk("fl_pop", 32'(FlPop), 32'(v.disp & v.e_drdy));
    chk("iss_valid", 32'(IssValid), 32'(v.e_ivalid));
    if (v.e_ivalid) chk("iss_tag", 32'(IssTag), 32'(v.e_itag));
    chk("fl_push", 32'(FlPush), 32'(v.e_push));
    chk("fl_clean", 32'(FlClean), 32'(v.flush));
    if (v.flush) sb.delete();
    else if (auto_sb && v.disp && v.e_drdy) sb.push_back('{tag: FlTag, pay: cur_pay});
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rest = 1'b1;  DispValid = 1'b1;  IssReady = 1'b1;  Flush = 1'b0;  WkValid = 1'b0;
    #1;
    chk("rst_disp_ready", 32'(DispReady), 32'd0);
    chk("rst_fl_pop", 32'(FlPop), 32'd0);
    chk("rst_fl_push", 32'(FlPush), 32'd0);
    chk("rst_iss_valid", 32'(IssValid), 32'd0);
    chk("rst_fl_clean", 32'(FlClean), 32'd1);
    chk("rst_iss_tag", 32'(IssTag), 32'd0);
    chk("rst_ret_tag", 32'(FlRetTag), 32'd0);
    chk("rst_iss_payload", IssPayload, 32'd0);
    sb.delete();
    @(negedge Clk);
    DispValid = 1'b0;  IssReady = 1'b0;
    @(negedge Clk);
    Rest = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, wanted $finish");
    $fatal(1);
  end

  initial begin
    // Eight ready dispatches fill the queue, the ninth stalls, then drain oldest first.
    for (int k = 0; k < 9; k++)
      tbl.push_back(mkv(1, k, 1, k + 1, 1, 0, 0, 0, 0, int'(k < 8), int'(k > 0), 2, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, int'(k > 0), 1, 4 * k + 2, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));

    do_reset();
    foreach (tbl[i]) step(tbl[i], 1'b1);

    // Late wakeup on src1; a non-matching broadcast must not wake it.
    do_reset();
    step(mkv(1, 5, 0, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 1, 4, 0, 0, 1, 0, 0, 0), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 1, 5, 0, 0, 1, 0, 0, 0), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2, 1), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0), 1'b1);

    // Same-cycle wakeup bypass on src1 and src2.
    do_reset();
    step(mkv(1, 9, 0, 3, 1, 1, 9, 0, 0, 1, 0, 0, 0), 1'b1);
    step(mkv(1, 1, 1, 12, 0, 1, 12, 0, 0, 1, 1, 2, 0), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2, 1), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 6, 1), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0), 1'b1);

    // Younger ready entry overtakes an older waiting one.
    do_reset();
    step(mkv(1, 20, 0, 21, 1, 0, 0, 0, 0, 1, 0, 0, 0), 1'b0);
    pay_a = cur_pay;
    step(mkv(1, 1, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0), 1'b0);
    pay_b = cur_pay;
    sb.push_back('{tag: 5'd6, pay: pay_b});
    sb.push_back('{tag: 5'd2, pay: pay_a});
    step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 6, 1), 1'b0);
    step(mkv(0, 0, 0, 0, 0, 1, 20, 1, 0, 1, 0, 0, 0), 1'b0);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2, 1), 1'b0);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0), 1'b0);

    // Backpressure: selection holds even when a younger entry becomes eligible.
    do_reset();
    step(mkv(1, 1, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    step(mkv(1, 3, 1, 4, 1, 0, 0, 0, 0, 1, 1, 2, 0), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2, 1), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 6, 1), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0), 1'b1);

    // Flush with three live entries, then the free list starts again at tag 2.
    do_reset();
    step(mkv(1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    step(mkv(1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 2, 0), 1'b1);
    step(mkv(1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 2, 0), 1'b1);
    step(mkv(1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0), 1'b1);
    @(posedge Clk);
    #1;
    chk("flush_fl_size", 32'(fl_q.size()), 32'd8);
    chk("flush_fl_head", 32'(FlTag), 32'd2);
    step(mkv(1, 1, 1, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2, 1), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0), 1'b1);

    // Reset with a live, issuable entry: nothing is released and the queue comes back empty.
    step(mkv(1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0), 1'b1);
    do_reset();
    step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0), 1'b1);
    chk("rst_fl_size", 32'(fl_q.size()), 32'd8);
    chk("rst_fl_head", 32'(FlTag), 32'd2);

    @(negedge Clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/int_iq3_queue.md
INT_IQ3_QUEUE -- requirements
Module: int_iq3_queue

Interface
REQ-001 SHALL have parameter TAGW, 5, slot tag width (matches IQ3 free-list entry width).
REQ-002 SHALL have parameter DEPTH, 8, number of issue-queue slots.
REQ-003 SHALL have parameter PRW, 6, physical register tag width.
REQ-004 SHALL have parameter PAYW, 32, opaque micro-op payload width.
REQ-005 SHALL have port Clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port Rest  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports DispValid in 1, DispReady out 1, DispPayload in PAYW, DispSrc1/DispSrc2 in PRW, DispSrc1Rdy/DispSrc2Rdy in 1: dispatch handshake and operand tags.
REQ-008 SHALL have ports FlPop out 1 (free-list read enable), FlTag in TAGW (free-list head, combinational), FlEmpty in 1: allocation side.
REQ-009 SHALL have ports FlPush out 1 (free-list write enable), FlRetTag out TAGW, FlClean out 1: release side.
REQ-010 SHALL have ports WkValid in 1, WkPreg in PRW: writeback wakeup broadcast.
REQ-011 SHALL have ports IssValid out 1, IssReady in 1, IssTag out TAGW, IssPayload out PAYW: issue handshake.
REQ-012 SHALL have port Flush in 1: pipeline flush.

Function
REQ-013 Slot index SHALL be FlTag[4:2]; legal tags are 2,6,10,...,30 mapping to slots 0..7.
REQ-014 DispReady SHALL equal !FlEmpty && !Flush && !Rest; accept = DispValid && DispReady; FlPop SHALL equal accept (same cycle).
REQ-015 On accept, the slot SHALL become valid at the next edge holding tag, payload, src tags and ready bits.
REQ-016 Captured src ready SHALL be DispSrcNRdy OR (WkValid && WkPreg == DispSrcN) in the accept cycle (same-cycle wakeup bypass).
REQ-017 Each valid entry whose not-ready src equals WkPreg while WkValid SHALL set that ready bit at the next edge.
REQ-018 Age: 8x8 age matrix; on allocating slot i, row i SHALL be loaded with the current valid vector (entries older than i); column i SHALL clear when slot i is released.
REQ-019 Eligible entry = valid && both src ready; IssValid SHALL be high (combinationally from registered state) when any entry is eligible and Flush is low.
REQ-020 Selection SHALL pick the eligible entry with no older eligible entry; IssTag/IssPayload SHALL be that entry's fields.
REQ-021 A newly dispatched entry SHALL NOT issue in its accept cycle; earliest issue is the cycle after.
REQ-022 On IssValid && IssReady: FlPush=1 and FlRetTag=IssTag in the same cycle; entry invalid at next edge.
REQ-023 IssReady low SHALL hold IssValid and IssTag stable (selection stable absent new eligibles older than it) and FlPush=0.
REQ-024 Simultaneous dispatch and issue SHALL both complete; a tag released in cycle N SHALL NOT be re-allocated in cycle N.
REQ-025 Flush SHALL clear all valid bits and the age matrix at the next edge; FlClean SHALL equal Flush; FlPush, FlPop and IssValid SHALL be 0 during Flush.
REQ-026 Dispatch to an already-valid slot is a protocol violation and SHALL fire a simulation assertion.

Reset
REQ-027 With Rest high at an edge: all valid bits, ready bits and age matrix SHALL clear.
REQ-028 While Rest high, DispReady, FlPop, FlPush, IssValid SHALL be 0; FlClean SHALL be 1; IssTag, FlRetTag, IssPayload SHALL be 0.
REQ-029 Reset mid-operation SHALL discard all entries without releasing tags.

Structure
REQ-030 Package int_iq3_pkg SHALL hold TAGW, DEPTH, PRW, entry struct type and tag-to-slot function.
REQ-031 Oldest-eligible selection SHALL be sub-module int_iq3_age_sel (eligible vector + age matrix in, one-hot grant + valid out).

Verification (bench instantiates the team's IQ3 free list)
REQ-032 Reset, 8 ready dispatches -> FlTag popped 2,6,...,30 in order; IssValid with IssTag=2 cycle after first accept; 9th dispatch sees DispReady=0.
REQ-033 Dispatch tag 2 with Src1=5 not ready; WkValid, WkPreg=5 two cycles later -> IssValid, IssTag=2 the following cycle.
REQ-034 Dispatch Src1=9 not ready with WkValid, WkPreg=9 same cycle -> IssValid next cycle.
REQ-035 Dispatch A (tag 2, unready), B (tag 6, ready) -> B issues first; wake A -> A issues; FlRetTag 6 then 2.
REQ-036 Eligible entry, IssReady=0 for 3 cycles -> IssValid held, IssTag stable, FlPush=0; IssReady=1 -> single FlPush.
REQ-037 Three valid entries, Flush one cycle -> FlClean=1, no FlPush, IssValid=0 next cycle, free list restored to 2..30.
